// File: rtl/dual_issue_hazard_unit.sv
// Dual-issue hazard unit: load-use stalls and intra-bundle RAW split issue for the ALU/LSU pipes.
// Latency: outputs are combinational from state and inputs. Backpressure: it holds PC and IF/ID, and it bubbles ID/EX per pipe. HAZ_STATS_EN adds stall and split counters.
module dual_issue_hazard_unit #(
    parameter int REG_W      = 3,
    parameter int LOAD_STALL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IF_ID_rm_1,
    input  logic [REG_W-1:0] IF_ID_rn_1,
    input  logic [REG_W-1:0] IF_ID_rd_1,
    input  logic             IF_ID_RegWrite1,
    input  logic [REG_W-1:0] IF_ID_rm_2,
    input  logic [REG_W-1:0] IF_ID_rn_2,
    input  logic [REG_W-1:0] IF_ID_rd_2,
    input  logic             IF_ID_MemWrite2,
    input  logic             ID_EX_MemRead2,
    input  logic [REG_W-1:0] ID_EX_rd_2,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Flush1,
`ifdef HAZ_STATS_EN
    output logic [15:0]      stall_cycles,
    output logic [15:0]      split_events,
`endif
    output logic             ID_EX_Flush2
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] SPLIT    = 2'd2;

    // The first bubble is issued from RUN, so LU_STALL counts only the remaining cycles.
    localparam bit         LP_MULTI    = (LOAD_STALL > 1);
    localparam logic [1:0] LP_CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

    logic [1:0] r_state;
    logic [1:0] r_stall_cnt;
    logic [1:0] w_state_nxt;
    logic [1:0] w_cnt_nxt;
    logic       w_lu_hit;
    logic       w_dep_hit;

    assign w_lu_hit = ID_EX_MemRead2 && (ID_EX_rd_2 != '0) &&
                      ((ID_EX_rd_2 == IF_ID_rm_1) || (ID_EX_rd_2 == IF_ID_rn_1) ||
                       (ID_EX_rd_2 == IF_ID_rm_2) || (ID_EX_rd_2 == IF_ID_rn_2) ||
                       (IF_ID_MemWrite2 && (ID_EX_rd_2 == IF_ID_rd_2)));

    assign w_dep_hit = IF_ID_RegWrite1 && (IF_ID_rd_1 != '0) &&
                       ((IF_ID_rd_1 == IF_ID_rm_2) || (IF_ID_rd_1 == IF_ID_rn_2) ||
                        (IF_ID_MemWrite2 && (IF_ID_rd_1 == IF_ID_rd_2)));

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Flush1 = 1'b0;
        ID_EX_Flush2 = 1'b0;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_stall_cnt;
        case (r_state)
            RUN: begin
                if (w_lu_hit) begin
                    {PCWrite, IF_ID_Write, ID_EX_Flush1, ID_EX_Flush2} = 4'b0011;
                    if (LP_MULTI) begin
                        w_state_nxt = LU_STALL;
                        w_cnt_nxt   = LP_CNT_INIT;
                    end
                end else if (w_dep_hit) begin
                    {PCWrite, IF_ID_Write, ID_EX_Flush1, ID_EX_Flush2} = 4'b0001;
                    w_state_nxt = SPLIT;
                end
            end
            LU_STALL: begin
                {PCWrite, IF_ID_Write, ID_EX_Flush1, ID_EX_Flush2} = 4'b0011;
                if (r_stall_cnt == 2'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_stall_cnt - 2'd1;
                end
            end
            SPLIT: begin
                // A late load-use on the held bundle takes precedence; the split completes afterwards.
                if (w_lu_hit) begin
                    {PCWrite, IF_ID_Write, ID_EX_Flush1, ID_EX_Flush2} = 4'b0011;
                end else begin
                    {PCWrite, IF_ID_Write, ID_EX_Flush1, ID_EX_Flush2} = 4'b1110;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
        if (reset) begin
            {PCWrite, IF_ID_Write, ID_EX_Flush1, ID_EX_Flush2} = 4'b1100;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_stall_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_cnt_nxt;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_split_events;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_split_events <= 16'd0;
        end else begin
            if (!PCWrite && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if ((r_state == SPLIT) && (w_state_nxt == RUN) && (r_split_events != 16'hFFFF)) begin
                r_split_events <= r_split_events + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign split_events = r_split_events;
`endif

endmodule
